// File: rtl/aes_key_expander.sv
// aes_key_expander
//   Expands a 128-bit AES cipher key into the 11 AES-128 round keys (round 0..10)
//   and streams them, one per accepted handshake, to the round datapath.
//   Round keys come from one working register, four S-box lookups and an Rcon register.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   key_in     cipher key; word 0 = [127:96], bytes big-endian within each word
//   key_valid  key_in valid         / key_ready  block can accept a new key
//   roundkey   current round key    / rk_round   its index, 0..10
//   rk_valid   roundkey valid       / rk_ready   consumer takes the current key
//   done       one-cycle pulse after round key 10 is taken
//   replay     re-emit the stored key set (only with KEYEXP_REPLAY_EN)
//   key_stored a complete key set is held in the store (only with KEYEXP_REPLAY_EN)
//
// Build option
//   KEYEXP_REPLAY_EN: adds an 11 x 128-bit key store plus replay. Without it,
//   replay is ignored and key_stored is constant 0.

module aes_key_expander #(
  parameter int unsigned W_KEY    = 128,
  parameter int unsigned N_ROUNDS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_KEY-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [W_KEY-1:0] roundkey,
  output logic [3:0]       rk_round,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             done,
  input  logic             replay,
  output logic             key_stored
);

  localparam logic [3:0] LAST_RND = 4'(N_ROUNDS);

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // ~x * 8 is the bit offset of entry x counted from the LSB end of the table.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W_KEY-1:0] r_work;
  logic [7:0]       r_rcon;
  logic [3:0]       r_round;
  logic             r_done;

  logic             w_accept_key;
  logic             w_accept_replay;
  logic             w_advance;
  logic             w_last;
  logic             w_replay_go;
  logic             w_from_store;

  // next_key(working register, Rcon)
  logic [31:0]      w_w0, w_w1, w_w2, w_w3;
  logic [31:0]      w_rot, w_t;
  logic [31:0]      w_n0, w_n1, w_n2, w_n3;
  logic [W_KEY-1:0] w_next_key;
  logic [7:0]       w_rcon_nxt;

  assign w_w0  = r_work[127:96];
  assign w_w1  = r_work[95:64];
  assign w_w2  = r_work[63:32];
  assign w_w3  = r_work[31:0];
  assign w_rot = {w_w3[23:0], w_w3[31:24]};
  assign w_t   = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                  sbox(w_rot[15:8]),  sbox(w_rot[7:0])} ^ {r_rcon, 24'h000000};
  assign w_n0  = w_w0 ^ w_t;
  assign w_n1  = w_w1 ^ w_n0;
  assign w_n2  = w_w2 ^ w_n1;
  assign w_n3  = w_w3 ^ w_n2;
  assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

  assign w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  always_comb begin
    w_state_nxt     = r_state;
    w_accept_key    = 1'b0;
    w_accept_replay = 1'b0;
    w_advance       = 1'b0;
    w_last          = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A fresh key takes priority over a replay request.
        if (key_valid) begin
          w_accept_key = 1'b1;
          w_state_nxt  = S_EMIT;
        end else if (w_replay_go) begin
          w_accept_replay = 1'b1;
          w_state_nxt     = S_EMIT;
        end
      end
      S_EMIT: begin
        if (rk_ready) begin
          if (r_round == LAST_RND) begin
            w_last      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_rcon  <= 8'h01;
      r_round <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_last;
      if (w_accept_key) begin
        r_work  <= key_in;
        r_round <= '0;
        r_rcon  <= 8'h01;
      end else if (w_accept_replay) begin
        r_round <= '0;
      end else if (w_advance) begin
        if (!w_from_store) begin
          r_work <= w_next_key;
          r_rcon <= w_rcon_nxt;
        end
        r_round <= r_round + 4'd1;
      end
    end
  end

  assign key_ready = (r_state == S_IDLE);
  assign rk_valid  = (r_state == S_EMIT);
  assign rk_round  = r_round;
  assign done      = r_done;

`ifdef KEYEXP_REPLAY_EN
  logic [W_KEY-1:0] r_store [0:N_ROUNDS];
  logic             r_replay;
  logic             r_stored;

  // The store captures each freshly computed key as it is handed over.
  always_ff @(posedge clk) begin
    if ((r_state == S_EMIT) && rk_ready && !r_replay) begin
      r_store[r_round] <= r_work;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_replay <= 1'b0;
      r_stored <= 1'b0;
    end else begin
      if (w_accept_key) begin
        r_replay <= 1'b0;
        r_stored <= 1'b0;
      end else if (w_accept_replay) begin
        r_replay <= 1'b1;
      end
      if (w_last) begin
        r_stored <= 1'b1;
      end
    end
  end

  assign w_replay_go  = replay & r_stored;
  assign w_from_store = r_replay;
  assign roundkey     = r_replay ? r_store[r_round] : r_work;
  assign key_stored   = r_stored;
`else
  assign w_replay_go  = 1'b0;
  assign w_from_store = 1'b0;
  assign roundkey     = r_work;
  // replay has no function in this build; the AND keeps the port consumed.
  assign key_stored   = replay & 1'b0;
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander
//   Directed bench for aes_key_expander. A reference model derives the S-box from
//   GF(2^8) inverses plus the affine map, and runs the textbook 44-word key schedule.
//   One compare routine checks every cycle against that model; fixed FIPS-197
//   vectors pin the model itself.

module tb_aes_key_expander;

  logic         clk;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] roundkey;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         done;
  logic         replay;
  logic         key_stored;

  aes_key_expander #(.W_KEY(128), .N_ROUNDS(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .roundkey   (roundkey),
    .rk_round   (rk_round),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .done       (done),
    .replay     (replay),
    .key_stored (key_stored)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] KA1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KZ   = 128'h0;
  localparam logic [127:0] Z1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZA   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;

  logic [7:0]   sb [256];
  logic [127:0] m_keys [0:10];
  logic [127:0] cap    [0:10];
  int unsigned  m_idx;
  logic         m_busy;
  logic         m_done;
  logic         m_stored;
  logic         m_stall;
  logic [127:0] m_prev_rk;
  logic [3:0]   m_prev_round;
  int unsigned  n_valid;
  int unsigned  n_done;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Checks the outputs seen between edges, then advances the model for the coming edge.
  task automatic monitor();
    if (!rst) begin
      chk("rst_rk_valid", 128'(rk_valid), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk("rst_key_stored", 128'(key_stored), 128'(0));
      chk("rst_roundkey", roundkey, 128'h0);
      chk("rst_rk_round", 128'(rk_round), 128'(0));
      m_busy = 1'b0; m_done = 1'b0; m_stored = 1'b0; m_stall = 1'b0; m_idx = 0;
      return;
    end
    chk("done", 128'(done), 128'(m_done));
    chk("rk_valid", 128'(rk_valid), 128'(m_busy));
    chk("key_ready", 128'(key_ready), 128'(!m_busy));
    chk("key_stored", 128'(key_stored), 128'(m_stored));
    if (done) n_done++;
    if (rk_valid) begin
      n_valid++;
      chk("roundkey", roundkey, m_keys[m_idx]);
      chk("rk_round", 128'(rk_round), 128'(m_idx));
    end
    if (m_stall) begin
      chk("stall_roundkey", roundkey, m_prev_rk);
      chk("stall_rk_round", 128'(rk_round), 128'(m_prev_round));
    end
    m_done       = 1'b0;
    m_stall      = m_busy && !rk_ready;
    m_prev_rk    = roundkey;
    m_prev_round = rk_round;
    if (m_busy) begin
      if (rk_ready) begin
        cap[m_idx] = roundkey;
        if (m_idx == 10) begin
          m_busy = 1'b0;
          m_done = 1'b1;
`ifdef KEYEXP_REPLAY_EN
          m_stored = 1'b1;
`endif
        end else begin
          m_idx++;
        end
      end
    end else if (key_valid) begin
      expand(key_in);
      m_busy = 1'b1; m_idx = 0; m_stored = 1'b0;
    end else if (replay && m_stored) begin
      m_busy = 1'b1; m_idx = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [127:0] k);
    n_valid   = 0;
    n_done    = 0;
    key_in    = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic run(input int unsigned budget, input bit rnd);
    for (int unsigned i = 0; i < budget; i++) begin
      rk_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      tick();
      if (!m_busy) return;
    end
    chk("expansion_timeout", 128'(1), 128'(0));
  endtask

  initial begin
    rst = 1'b0; key_in = '0; key_valid = 1'b0; rk_ready = 1'b0; replay = 1'b0;
    m_busy = 1'b0; m_done = 1'b0; m_stored = 1'b0; m_stall = 1'b0; m_idx = 0;
    n_valid = 0; n_done = 0;
    build_sbox();
    chk("model_sbox_00", 128'(sb[0]), 128'h63);
    chk("model_sbox_53", 128'(sb[8'h53]), 128'hed);

    repeat (2) tick();
    rst = 1'b1;
    tick();

    // FIPS-197 A.1 key, consumer always ready
    start(KA1);
    run(100, 1'b0);
    tick();
    chk("a1_round0", cap[0], KA1);
    chk("a1_round1", cap[1], A1R1);
    chk("a1_round10", cap[10], A1RA);
    chk("a1_valid_cycles", 128'(n_valid), 128'(11));
    chk("a1_done_pulses", 128'(n_done), 128'(1));

    // Same key, consumer stalls randomly
    start(KA1);
    run(500, 1'b1);
    tick();
    chk("stall_round1", cap[1], A1R1);
    chk("stall_round10", cap[10], A1RA);
    chk("stall_done_pulses", 128'(n_done), 128'(1));

    // key_valid held through EMIT with a different key
    key_in = KA1; key_valid = 1'b1;
    tick();
    key_in = KZ;
    run(100, 1'b0);
    chk("hold_round10_first", cap[10], A1RA);
    tick();
    key_valid = 1'b0;
    run(100, 1'b0);
    tick();
    chk("hold_second_round0", cap[0], KZ);
    chk("zero_round1", cap[1], Z1);
    chk("zero_round10", cap[10], ZA);

    // Reset while round key 5 is presented
    start(KA1);
    rk_ready = 1'b1;
    repeat (5) tick();
    chk("pre_reset_round", 128'(m_idx), 128'(5));
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    start(KA1);
    run(100, 1'b0);
    tick();
    chk("post_reset_round1", cap[1], A1R1);
    chk("post_reset_round10", cap[10], A1RA);

    // Replay request
    replay = 1'b1;
    tick();
    replay = 1'b0;
`ifdef KEYEXP_REPLAY_EN
    run(500, 1'b1);
    tick();
    chk("replay_round0", cap[0], KA1);
    chk("replay_round1", cap[1], A1R1);
    chk("replay_round10", cap[10], A1RA);
    key_in = KZ; key_valid = 1'b1; replay = 1'b1;
    tick();
    key_valid = 1'b0; replay = 1'b0;
    run(100, 1'b0);
    tick();
    chk("replay_newkey_round1", cap[1], Z1);
    chk("replay_newkey_round10", cap[10], ZA);
`else
    repeat (3) tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Upstream neighbour of the encryption round unit: expands a 128-bit AES cipher key into the 11 AES-128 round keys (round 0..10), per FIPS-197.
- Presents one round key at a time on a valid/ready stream, in round order. The round datapath consumes each key on its `roundkey` input.
- Generates one round key per cycle from a single 128-bit working register. Uses 4 internal S-box lookups (SubWord) and an Rcon register.

Parameters:
- W_KEY, 128, key and round-key width. Only 128 is supported.
- N_ROUNDS, 10, index of the last round key emitted (11 keys in total).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- key_in  in  W_KEY  cipher key. Word 0 is bits [127:96]; bytes are big-endian within each word.
- key_valid  in  1  key_in is valid.
- key_ready  out  1  block accepts a new key.
- roundkey  out  W_KEY  current round key.
- rk_round  out  4  index of the current round key, 0..10.
- rk_valid  out  1  roundkey and rk_round are valid.
- rk_ready  in  1  consumer accepts the current round key.
- done  out  1  one-cycle pulse after round key 10 is accepted.
- replay  in  1  re-emit stored keys (see Optional Feature).
- key_stored  out  1  full key set is stored (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - key_ready=1 once released; rk_valid=0, done=0, key_stored=0.
  - roundkey=0, rk_round=0, Rcon=0x01.
  - Reset mid-expansion aborts immediately; no further keys are emitted.
- FSM states:
  - IDLE: key_ready=1, rk_valid=0.
    - On key_valid & key_ready: working register <= key_in, rk_round <= 0, Rcon <= 0x01, go to EMIT.
  - EMIT: key_ready=0, rk_valid=1, roundkey = working register.
    - While rk_ready=0: roundkey and rk_round hold stable. Standard valid/ready; no combinational ready->valid path.
    - On rk_ready with rk_round < 10: working register <= next_key(working register, Rcon); Rcon <= xtime(Rcon); rk_round++. Stay in EMIT.
    - On rk_ready with rk_round == 10: go to IDLE; done=1 for the next cycle only.
- Latency:
  - Key accepted at edge N: round 0 key valid in the cycle after edge N.
  - Each subsequent key is valid in the cycle after the previous acceptance.
  - With rk_ready held high: 11 consecutive valid cycles.
- key_valid during EMIT is ignored, since key_ready=0; key_in is not sampled.
- The next key may be accepted in the same cycle that done is high (state is IDLE).
- next_key computation, with w0..w3 the current words:
  - t = SubWord(RotWord(w3)) XOR {Rcon,00,00,00}.
  - RotWord(b0 b1 b2 b3) = b1 b2 b3 b0.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- Rcon arithmetic:
  - xtime(x) = (x<<1)[7:0], XORed with 0x1B if x[7]=1.
  - Sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- S-box: forward AES S-box, combinational lookup table inside this block, 4 instances.

Optional Feature:
- Macro: KEYEXP_REPLAY_EN.
- Defined:
  - An 11 x 128-bit key store is written with each round key as it is accepted.
  - key_stored=1 after round key 10 is accepted. It is cleared on reset and on acceptance of a new key.
  - In IDLE with key_stored=1, a replay pulse enters EMIT reading keys from the store, with no recomputation. The sequence, handshake and done behaviour are identical to a normal expansion.
  - If replay and key_valid are both high in IDLE, key_valid wins.
- Not defined:
  - No store is built; replay is ignored and key_stored is tied to 0.

Test Plan:
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 throughout:
  - round 0 = key_in;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - exactly 11 valid cycles, then one done pulse.
- Same key, rk_ready toggled randomly -> identical key sequence; roundkey and rk_round stable whenever rk_valid=1 and rk_ready=0.
- key_valid held high during EMIT with a different key_in -> expansion unaffected; the second key is accepted only in IDLE, with round 0 equal to the second key.
- rst asserted at rk_round=5 -> rk_valid falls immediately; after release key_ready=1, and a new expansion starts from round 0 with Rcon=0x01.
- All-zero key -> round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- KEYEXP_REPLAY_EN defined: after the A.1 expansion, key_stored=1; replay yields the same 11 keys. Then a new key clears key_stored until its round 10 is accepted.
